// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/result bundle of the bit-serial subtractor.
// SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, ovf
  );
  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, ovf
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
  );
  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first A-B, one bit per clock, borrow flop.
// SERIAL_SUB_OVF_EN adds a signed-overflow flag next to diff.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bf_q, bf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic             d_bit;
  logic             bf_nxt;
  logic [WIDTH-1:0] res_nxt;

`ifdef SERIAL_SUB_OVF_EN
  logic am_q, am_d;
  logic bm_q, bm_d;
  logic ovf_q, ovf_d;
`endif

  // Full-subtractor cell, next result word and FSM/datapath control
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    bf_d     = bf_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    am_d     = am_q;
    bm_d     = bm_q;
    ovf_d    = ovf_q;
`endif
    d_bit   = sa_q[0] ^ sb_q[0] ^ bf_q;
    bf_nxt  = (~sa_q[0] & sb_q[0])
            | (~(sa_q[0] ^ sb_q[0]) & bf_q);
    res_nxt = {d_bit, res_q[WIDTH-1:1]};
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          res_d   = '0;
          bf_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
          am_d    = bus.a[WIDTH-1];
          bm_d    = bus.b[WIDTH-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        res_d = res_nxt;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        bf_d  = bf_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          diff_d   = res_nxt;
          borrow_d = bf_nxt;
          state_d  = DONE;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = (am_q != bm_q)
                  && (res_nxt[WIDTH-1] != am_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      bf_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      am_q     <= 1'b0;
      bm_q     <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      bf_q     <= bf_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      am_q     <= am_d;
      bm_q     <= bm_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy   = (state_q == SHIFT);
  assign bus.done   = (state_q == DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor.
// Expected results are queued at launch and popped on done.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   done_cnt;
  logic [9:0] sb_q[$];

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // {ovf, borrow, diff} from plain wide arithmetic
  function automatic logic [9:0] model(input logic [7:0] a_i,
                                       input logic [7:0] b_i);
    logic [8:0] w;
    logic       o;
    w = {1'b0, a_i} - {1'b0, b_i};
    o = (a_i[7] != b_i[7]) && (w[7] != a_i[7]);
    return {o, w[8], w[7:0]};
  endfunction

  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n && bus.done) begin
      done_cnt++;
      chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("diff", 32'(bus.diff), 32'(e[7:0]));
        chk("borrow", 32'(bus.borrow), 32'(e[8]));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", 32'(bus.ovf), 32'(e[9]));
`endif
      end
    end
  end

  task automatic launch(input logic [7:0] a_i,
                        input logic [7:0] b_i,
                        input bit push);
    bus.start = 1'b1;
    bus.a     = a_i;
    bus.b     = b_i;
    if (push) sb_q.push_back(model(a_i, b_i));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
  endtask

  task automatic wait_done(output int nbusy);
    int k;
    nbusy = 0;
    k     = 0;
    while (!bus.done && k < 50) begin
      if (bus.busy) nbusy++;
      k++;
      @(negedge clk);
    end
    chk("done_seen", 32'(bus.done), 1);
  endtask

  task automatic op(input logic [7:0] a_i,
                    input logic [7:0] b_i);
    int n;
    launch(a_i, b_i, 1'b1);
    wait_done(n);
    chk("busy_len", 32'(n), W);
    @(negedge clk);
    chk("done_1cyc", 32'(bus.done), 0);
    chk("idle_busy", 32'(bus.busy), 0);
  endtask

  initial begin
    int d0;
    int n;
    int gap;
    total     = 0;
    bad       = 0;
    done_cnt  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_diff", 32'(bus.diff), 0);
    chk("rst_borrow", 32'(bus.borrow), 0);
    rst_n = 1'b1;
    @(negedge clk);

    op(8'h05, 8'h03);

    launch(8'hF0, 8'h0F, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_done", 32'(bus.done), 0);
    chk("arst_diff", 32'(bus.diff), 0);
    chk("arst_borrow", 32'(bus.borrow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (15) @(negedge clk);
    chk("no_done_after_rst", 32'(done_cnt - d0), 0);

    op(8'h00, 8'h01);
    op(8'hA5, 8'hA5);
    op(8'h00, 8'h00);
    op(8'hFF, 8'h00);
    op(8'h7F, 8'h80);
`ifdef SERIAL_SUB_OVF_EN
    op(8'h80, 8'h01);
`endif
    for (int i = 0; i < 4; i++)
      op(8'($urandom), 8'($urandom));

    d0 = done_cnt;
    launch(8'h40, 8'h10, 1'b1);
    repeat (2) @(negedge clk);
    launch(8'h11, 8'h22, 1'b0);
    wait_done(n);
    repeat (12) @(negedge clk);
    chk("ign_one_done", 32'(done_cnt - d0), 1);

    launch(8'h33, 8'h11, 1'b1);
    wait_done(n);
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    sb_q.push_back(model(8'h10, 8'h20));
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy", 32'(bus.busy), 1);
    gap = 1;
    while (!bus.done && gap < 50) begin
      gap++;
      @(negedge clk);
    end
    chk("b2b_gap", 32'(gap), 9);
    repeat (3) @(negedge clk);

    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
